// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions used by the master and slave.
// Transfer/burst encodings, size constants and the command legality check.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR4  = 3'b011
  } hburst_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ADDR      = 2'b01,
    ST_DATA_LAST = 2'b10,
    ST_ERR2      = 2'b11
  } mst_state_t;

  localparam logic [2:0]  HSIZE_BYTE  = 3'b000;
  localparam logic [2:0]  HSIZE_HALF  = 3'b001;
  localparam logic [2:0]  HSIZE_WORD  = 3'b010;
  localparam logic        HRESP_OKAY  = 1'b0;
  localparam logic        HRESP_ERROR = 1'b1;
  localparam logic [10:0] KB_BOUNDARY = 11'd1024;

  // True when a command is misaligned, oversized, or an INCR4 leaves its 1 KB page.
  function automatic logic cmd_illegal(input logic [9:0] addr_lo,
                                       input logic [2:0] size,
                                       input logic       incr4);
    logic        misalign;
    logic [10:0] end_off;
    case (size)
      HSIZE_HALF: misalign = addr_lo[0];
      HSIZE_WORD: misalign = |addr_lo[1:0];
      default:    misalign = 1'b0;
    endcase
    end_off = {1'b0, addr_lo} + (11'd4 << size);
    return (size > HSIZE_WORD) || misalign || (incr4 && (end_off > KB_BOUNDARY));
  endfunction

endpackage

// File: rtl/amba_ahb_master.sv
// AHB-Lite initiator: turns client commands into SINGLE/INCR4 transfers with
// wait-state stalls, BUSY insertion for late write data and two-cycle ERROR handling.
module amba_ahb_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic              cmd_incr4,
  input  logic              wd_valid,
  input  logic [DATA_W-1:0] wd_data,
  output logic              wd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              done_err,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [1:0]        htrans,
  output logic [3:0]        hprot,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);

  mst_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        beat_q, beat_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic              incr4_q, incr4_d;
  logic              dph_q, dph_d;
  logic              dlast_q, dlast_d;
  logic              dread_q, dread_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  htrans_t           htrans_s;
  logic              addr_go_s;
  logic              err1_s;
  logic              last_beat_s;

  // Transfer type for the pending beat; a write without data waits as IDLE (beat 0) or BUSY.
  always_comb begin
    htrans_s = HTRANS_IDLE;
    if (state_q == ST_ADDR) begin
      if (write_q && !wd_valid) begin
        htrans_s = (beat_q == 2'd0) ? HTRANS_IDLE : HTRANS_BUSY;
      end else begin
        htrans_s = (beat_q == 2'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      end
    end else begin
      htrans_s = HTRANS_IDLE;
    end
  end

  assign addr_go_s   = (state_q == ST_ADDR) && hready &&
                       ((htrans_s == HTRANS_NONSEQ) || (htrans_s == HTRANS_SEQ));
  assign err1_s      = dph_q && (hresp == HRESP_ERROR) && !hready;
  assign last_beat_s = (beat_q == (incr4_q ? 2'd3 : 2'd0));

  // Next-state logic: data-phase retirement first, then address-phase sequencing.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    write_d    = write_q;
    size_d     = size_q;
    incr4_d    = incr4_q;
    dph_d      = dph_q;
    dlast_d    = dlast_q;
    dread_d    = dread_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (dph_q && hready) begin
      dph_d = 1'b0;
      if (dread_q && (hresp == HRESP_OKAY)) begin
        rd_valid_d = 1'b1;
        rd_data_d  = hrdata;
        rd_last_d  = dlast_q;
      end else begin
        rd_valid_d = 1'b0;
      end
    end else begin
      dph_d = dph_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_illegal(cmd_addr[9:0], cmd_size, cmd_incr4)) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = ST_ADDR;
            addr_d  = cmd_addr;
            write_d = cmd_write;
            size_d  = cmd_size;
            incr4_d = cmd_incr4;
            beat_d  = 2'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (err1_s) begin
          state_d = ST_ERR2;
        end else if (addr_go_s) begin
          dph_d   = 1'b1;
          dlast_d = last_beat_s;
          dread_d = !write_q;
          if (write_q) begin
            hwdata_d = wd_data;
          end else begin
            hwdata_d = hwdata_q;
          end
          if (last_beat_s) begin
            state_d = ST_DATA_LAST;
          end else begin
            beat_d = beat_q + 2'd1;
            addr_d = addr_q + (ADDR_W'(1) << size_q);
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA_LAST: begin
        if (err1_s) begin
          state_d = ST_ERR2;
        end else if (hready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = hresp;
        end else begin
          state_d = ST_DATA_LAST;
        end
      end
      ST_ERR2: begin
        if (hready) begin
          state_d = ST_IDLE;
          dph_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = ST_ERR2;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      beat_q     <= 2'd0;
      write_q    <= 1'b0;
      size_q     <= 3'd0;
      incr4_q    <= 1'b0;
      dph_q      <= 1'b0;
      dlast_q    <= 1'b0;
      dread_q    <= 1'b0;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      write_q    <= write_d;
      size_q     <= size_d;
      incr4_q    <= incr4_d;
      dph_q      <= dph_d;
      dlast_q    <= dlast_d;
      dread_q    <= dread_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && !hreset;
  assign wd_ready  = addr_go_s && write_q && !hreset;
  assign htrans    = htrans_s;
  assign haddr     = addr_q;
  assign hwrite    = write_q;
  assign hsize     = size_q;
  assign hburst    = incr4_q ? HBURST_INCR4 : HBURST_SINGLE;
  assign hprot     = HPROT_VAL;
  assign hwdata    = hwdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign done      = done_q;
  assign done_err  = err_q;

endmodule

// File: tb/tb_amba_ahb_master.sv
// Directed cycle-by-cycle bench for amba_ahb_master; the bench plays the slave
// and checks every bus/client output against hand-computed values.
module tb_amba_ahb_master;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_incr4;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid, rd_last, done, done_err;
  logic [31:0] rd_data;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hready, hresp;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [3:0]  hprot;

  int n_tests = 0;
  int n_fail  = 0;

  amba_ahb_master #(.ADDR_W(32), .DATA_W(32), .HPROT_VAL(4'b0011)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_incr4(cmd_incr4),
    .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_err(done_err),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .htrans(htrans), .hprot(hprot), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 hclk = ~hclk;

  task automatic cyc();
    @(posedge hclk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic w, input logic [31:0] a, input logic [2:0] s, input logic i4);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_incr4 = i4;
  endtask

  initial begin
    hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_size = 3'd0; cmd_incr4 = 1'b0; wd_valid = 1'b0; wd_data = 32'h0;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;

    // reset
    cyc(); cyc(); #1;
    chk("rst_htrans", htrans, T_IDLE);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwrite", hwrite, 1'b0);
    chk("rst_hburst", hburst, 3'd0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_hprot", hprot, 4'b0011);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    cyc(); hreset = 1'b0; #1;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // SINGLE write 0x10, zero wait
    cyc(); set_cmd(1'b1, 32'h10, 3'd2, 1'b0); wd_valid = 1'b1; wd_data = 32'hDEADBEEF; #1;
    chk("w1_cmd_ready", cmd_ready, 1'b1);
    cyc(); cmd_valid = 1'b0; #1;
    chk("w1_htrans", htrans, T_NSEQ);
    chk("w1_haddr", haddr, 32'h10);
    chk("w1_hwrite", hwrite, 1'b1);
    chk("w1_hburst", hburst, 3'b000);
    chk("w1_wd_ready", wd_ready, 1'b1);
    chk("w1_cmd_busy", cmd_ready, 1'b0);
    cyc(); wd_valid = 1'b0; #1;
    chk("w1_htrans_idle", htrans, T_IDLE);
    chk("w1_hwdata", hwdata, 32'hDEADBEEF);
    chk("w1_no_done_yet", done, 1'b0);
    cyc(); #1;
    chk("w1_done", done, 1'b1);
    chk("w1_done_err", done_err, 1'b0);
    cyc(); #1;
    chk("w1_done_pulse", done, 1'b0);

    // INCR4 read 0x100
    set_cmd(1'b0, 32'h100, 3'd2, 1'b1); #1;
    cyc(); cmd_valid = 1'b0; #1;
    chk("r4_htrans0", htrans, T_NSEQ);
    chk("r4_haddr0", haddr, 32'h100);
    chk("r4_hburst", hburst, 3'b011);
    cyc(); hrdata = 32'h11; #1;
    chk("r4_htrans1", htrans, T_SEQ);
    chk("r4_haddr1", haddr, 32'h104);
    cyc(); hrdata = 32'h22; #1;
    chk("r4_haddr2", haddr, 32'h108);
    chk("r4_rd_valid0", rd_valid, 1'b1);
    chk("r4_rd_data0", rd_data, 32'h11);
    chk("r4_rd_last0", rd_last, 1'b0);
    cyc(); hrdata = 32'h33; #1;
    chk("r4_haddr3", haddr, 32'h10C);
    chk("r4_htrans3", htrans, T_SEQ);
    chk("r4_rd_data1", rd_data, 32'h22);
    cyc(); hrdata = 32'h44; #1;
    chk("r4_htrans_idle", htrans, T_IDLE);
    chk("r4_rd_data2", rd_data, 32'h33);
    chk("r4_no_done", done, 1'b0);
    cyc(); hrdata = 32'h0; #1;
    chk("r4_rd_valid3", rd_valid, 1'b1);
    chk("r4_rd_data3", rd_data, 32'h44);
    chk("r4_rd_last3", rd_last, 1'b1);
    chk("r4_done", done, 1'b1);
    chk("r4_done_err", done_err, 1'b0);
    cyc(); #1;
    chk("r4_rd_valid_end", rd_valid, 1'b0);

    // INCR4 write 0x100 with two BUSY cycles before beat 2
    set_cmd(1'b1, 32'h100, 3'd2, 1'b1); wd_valid = 1'b1; wd_data = 32'hA0; #1;
    cyc(); cmd_valid = 1'b0; #1;
    chk("wb_htrans0", htrans, T_NSEQ);
    chk("wb_wd_ready0", wd_ready, 1'b1);
    cyc(); wd_data = 32'hA1; #1;
    chk("wb_htrans1", htrans, T_SEQ);
    chk("wb_haddr1", haddr, 32'h104);
    chk("wb_hwdata0", hwdata, 32'hA0);
    cyc(); wd_valid = 1'b0; #1;
    chk("wb_busy1", htrans, T_BUSY);
    chk("wb_busy1_addr", haddr, 32'h108);
    chk("wb_busy1_wd_ready", wd_ready, 1'b0);
    chk("wb_hwdata1", hwdata, 32'hA1);
    cyc(); #1;
    chk("wb_busy2", htrans, T_BUSY);
    chk("wb_busy2_addr", haddr, 32'h108);
    chk("wb_busy2_hburst", hburst, 3'b011);
    cyc(); wd_valid = 1'b1; wd_data = 32'hA2; #1;
    chk("wb_htrans2", htrans, T_SEQ);
    chk("wb_haddr2", haddr, 32'h108);
    chk("wb_wd_ready2", wd_ready, 1'b1);
    cyc(); wd_data = 32'hA3; #1;
    chk("wb_haddr3", haddr, 32'h10C);
    chk("wb_hwdata2", hwdata, 32'hA2);
    cyc(); wd_valid = 1'b0; #1;
    chk("wb_htrans_idle", htrans, T_IDLE);
    chk("wb_hwdata3", hwdata, 32'hA3);
    cyc(); #1;
    chk("wb_done", done, 1'b1);
    chk("wb_done_err", done_err, 1'b0);

    // INCR4 read 0x40 with 3 wait states on beat 1
    cyc(); set_cmd(1'b0, 32'h40, 3'd2, 1'b1); #1;
    cyc(); cmd_valid = 1'b0; #1;
    chk("ws_htrans0", htrans, T_NSEQ);
    cyc(); hrdata = 32'h55; #1;
    chk("ws_haddr1", haddr, 32'h44);
    for (int k = 0; k < 3; k++) begin
      cyc(); hready = 1'b0; hrdata = 32'h0; #1;
      chk("ws_stall_htrans", htrans, T_SEQ);
      chk("ws_stall_haddr", haddr, 32'h48);
      chk("ws_stall_rd_valid", rd_valid, (k == 0) ? 1'b1 : 1'b0);
      chk("ws_stall_done", done, 1'b0);
    end
    cyc(); hready = 1'b1; hrdata = 32'h66; #1;
    chk("ws_rd_data0", rd_data, 32'h55);
    chk("ws_haddr2", haddr, 32'h48);
    cyc(); hrdata = 32'h77; #1;
    chk("ws_rd_data1", rd_data, 32'h66);
    chk("ws_haddr3", haddr, 32'h4C);
    cyc(); hrdata = 32'h88; #1;
    chk("ws_rd_data2", rd_data, 32'h77);
    chk("ws_no_done", done, 1'b0);
    cyc(); hrdata = 32'h0; #1;
    chk("ws_rd_data3", rd_data, 32'h88);
    chk("ws_rd_last", rd_last, 1'b1);
    chk("ws_done", done, 1'b1);

    // ERROR on beat 1 of INCR4 read 0x80
    cyc(); set_cmd(1'b0, 32'h80, 3'd2, 1'b1); #1;
    cyc(); cmd_valid = 1'b0; #1;
    cyc(); hrdata = 32'h99; #1;
    cyc(); hready = 1'b0; hresp = 1'b1; hrdata = 32'h0; #1;
    chk("er_first_htrans", htrans, T_SEQ);
    chk("er_rd_valid0", rd_valid, 1'b1);
    chk("er_rd_data0", rd_data, 32'h99);
    cyc(); hready = 1'b1; hresp = 1'b1; #1;
    chk("er_cancel_htrans", htrans, T_IDLE);
    chk("er_no_rd", rd_valid, 1'b0);
    chk("er_no_done", done, 1'b0);
    cyc(); hresp = 1'b0; #1;
    chk("er_done", done, 1'b1);
    chk("er_done_err", done_err, 1'b1);
    chk("er_htrans_idle", htrans, T_IDLE);
    chk("er_no_rd2", rd_valid, 1'b0);
    cyc(); #1;
    chk("er_stays_idle", htrans, T_IDLE);
    chk("er_done_pulse", done, 1'b0);

    // rejected commands: 1 KB crossing, misaligned, oversize
    set_cmd(1'b0, 32'h3F8, 3'd2, 1'b1); #1;
    cyc(); cmd_valid = 1'b0; #1;
    chk("rj_kb_htrans", htrans, T_IDLE);
    chk("rj_kb_done", done, 1'b1);
    chk("rj_kb_err", done_err, 1'b1);
    chk("rj_kb_ready", cmd_ready, 1'b1);
    cyc(); set_cmd(1'b1, 32'h102, 3'd2, 1'b0); #1;
    chk("rj_gap_done", done, 1'b0);
    cyc(); cmd_valid = 1'b0; #1;
    chk("rj_al_htrans", htrans, T_IDLE);
    chk("rj_al_done", done, 1'b1);
    chk("rj_al_err", done_err, 1'b1);
    cyc(); set_cmd(1'b0, 32'h200, 3'd3, 1'b0); #1;
    cyc(); cmd_valid = 1'b0; #1;
    chk("rj_sz_err", done_err, 1'b1);
    chk("rj_sz_htrans", htrans, T_IDLE);

    // legal INCR4 ending exactly on the 1 KB boundary
    cyc(); set_cmd(1'b0, 32'h3F0, 3'd2, 1'b1); #1;
    cyc(); cmd_valid = 1'b0; #1;
    chk("kb_edge_htrans", htrans, T_NSEQ);
    chk("kb_edge_no_err", done, 1'b0);

    // reset mid-transfer drops the command with no done
    cyc(); hreset = 1'b1; #1;
    chk("mr_during_ready", cmd_ready, 1'b0);
    cyc(); hreset = 1'b0; #1;
    chk("mr_htrans", htrans, T_IDLE);
    chk("mr_ready", cmd_ready, 1'b1);
    cyc(); #1;
    chk("mr_no_done", done, 1'b0);
    chk("mr_no_rd", rd_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/amba_ahb_master.md
# amba_ahb_master

AHB-Lite initiator that turns single-command requests from a local client into AHB-Lite SINGLE or INCR4 transfers, driving the same signal set the `amba_ahb_slave` responds to. It owns address/data phase pipelining, wait-state (HREADY) stalls, BUSY insertion when write data is late, and the two-cycle ERROR response. It sits between a test/DMA-style client and the bus fabric; HSEL comes from the system decoder, not this block.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: bus data width (hsize above 3'b010 is illegal).
- `HPROT_VAL`, 4'b0011: constant driven on hprot.
- `hclk` in 1: bus clock; everything is on its rising edge.
- `hreset` in 1: one clock; reset is synchronous and active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: start address.
- `cmd_size` in 3: HSIZE encoding.
- `cmd_incr4` in 1: 0 = SINGLE, 1 = INCR4.
- `wd_valid` in 1 / `wd_data` in DATA_W / `wd_ready` out 1: write-beat stream, one beat per transfer.
- `rd_valid` out 1 / `rd_data` out DATA_W / `rd_last` out 1: read beats, no backpressure.
- `done` out 1: one-cycle pulse when a command finishes.
- `done_err` out 1: qualifies `done`; 1 = error response or rejected command.
- `haddr`, `hwrite`, `hsize`, `hburst`, `htrans`, `hprot`, `hwdata` out: AHB-Lite master outputs.
- `hready` in 1, `hresp` in 1, `hrdata` in DATA_W: slave responses.

## Operation
- FSM states: IDLE, ADDR, DATA_LAST, ERR2.
- IDLE: `cmd_ready`=1, htrans=IDLE. On accept, check the command. Reject if `cmd_addr` is not aligned to `cmd_size`, if `cmd_size` > 3'b010, or if INCR4 crosses a 1 KB boundary. A rejected command pulses `done`/`done_err` on the next cycle with no bus activity.
- ADDR: drive the address phase. First beat is NONSEQ. Later beats are SEQ, with haddr += 1<<hsize. hburst is SINGLE(000) or INCR4(011). The beat counter runs 0..3.
- Write beat with `wd_valid`=0 when its address phase is due: drive BUSY (only inside a burst, after beat 0), holding haddr/hburst. For the first beat, stay at htrans=IDLE until the data is present.
- The address phase advances only on `hready`=1. After the last address is accepted, go to DATA_LAST and drive htrans=IDLE.
- DATA_LAST: wait for `hready`=1, then pulse `done` and return to IDLE.
- Error: `hresp`=1 & `hready`=0 in any data phase. On the next cycle force htrans=IDLE, cancelling the remaining beats, and go to ERR2. On `hresp`=1 & `hready`=1, pulse `done` with `done_err`=1.
- Read data: `rd_valid`=1 for one cycle per completed OKAY read data phase. `rd_data`=hrdata at that edge. `rd_last` is set on the final beat. No rd_valid on error beats.
- Reset values: htrans=00, haddr=0, hwrite=0, hsize=0, hburst=0, hwdata=0, hprot=HPROT_VAL, cmd_ready=0 during reset and 1 in the first IDLE cycle after it, wd_ready=0, rd_valid=0, rd_last=0, done=0, done_err=0.
- Reset asserted mid-transfer returns to IDLE on the next edge and drops any in-flight command; there is no `done`.

## Timing
- Address phase at cycle N with hready=1 → data phase at N+1. hwdata is registered and valid throughout the data phase.
- `wd_ready` is asserted in the cycle the matching address phase is accepted (hready=1, htrans NONSEQ/SEQ). The beat is consumed that edge, and hwdata is loaded at the same edge.
- Zero-wait SINGLE: cmd accept at C; address phase C+1; data phase C+2; `done` at C+3. Back-to-back commands are not pipelined: `cmd_ready` is 0 from accept until `done`.
- Zero-wait INCR4: address phases C+1..C+4, last data phase C+5, `done` C+6.
- Each hready=0 cycle stretches the current phase by one cycle. All outputs hold during a stall.

## Structure
- Shared package `ahb_pkg`: `htrans_t` (IDLE/BUSY/NONSEQ/SEQ), `hburst_t`, HSIZE constants, HRESP OKAY/ERROR, 1 KB boundary constant. The slave uses the same package.
- Single module; no sub-module. Address incrementer and beat counter stay inline.

## Test plan
- SINGLE write 0x0000_0010, size word, data 0xDEADBEEF, zero wait → NONSEQ/SINGLE one cycle, hwdata 0xDEADBEEF next cycle, `done`=1 `done_err`=0 at C+3.
- INCR4 read from 0x100, slave returns 0x11,0x22,0x33,0x44 → haddr 0x100,0x104,0x108,0x10C (NONSEQ,SEQ×3), four rd_valid with rd_last on 0x44.
- INCR4 write with wd_valid low for 2 cycles before beat 2 → two BUSY cycles at haddr 0x108, then SEQ resumes, all 4 beats written in order.
- Read with slave inserting 3 hready=0 cycles on beat 1 → all master outputs frozen 3 cycles, data correct, `done` delayed by 3.
- ERROR on beat 1 of INCR4 → htrans=IDLE the cycle after the first error cycle, no beats 2-3 issued, `done`&`done_err` after second error cycle.
- INCR4 word at 0x3F8 (crosses 1 KB), and word at 0x102 → `done_err`=1, htrans stays IDLE throughout.
